bus_arbiter2: RTL and testbench

BUS_ARBITER2 -- requirements
Module: bus_arbiter2

---
 rtl/bus_pkg.sv | 13 +
 rtl/bus_arbiter2.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter2.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master pipelined-bus arbiter.
// Holds the grant-state encoding and the default data width.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } bus_state_t;

  localparam int DefaultDataWidth = 32;

endpackage

// File: rtl/bus_arbiter2.sv
// Two-master to one-slave pipelined-bus arbiter with alternating tie-break.
// The granted master keeps the slave until it drops cyc and every accepted request has been answered.
module bus_arbiter2
  import bus_pkg::*;
#(
  parameter int AddrWidth      = 30,
  parameter int DataWidth      = DefaultDataWidth,
  parameter int MaxOutstanding = 4,
  localparam int SelWidth      = DataWidth / 8,
  localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 m0_bus_cyc,
  input  logic                 m0_bus_stb,
  input  logic                 m0_bus_we,
  input  logic [AddrWidth-1:0] m0_bus_addr,
  input  logic [DataWidth-1:0] m0_bus_data_m,
  input  logic [SelWidth-1:0]  m0_bus_sel,
  output logic [DataWidth-1:0] m0_bus_data_s,
  output logic                 m0_bus_ack,
  output logic                 m0_bus_stall,
  output logic                 m0_bus_err,

  input  logic                 m1_bus_cyc,
  input  logic                 m1_bus_stb,
  input  logic                 m1_bus_we,
  input  logic [AddrWidth-1:0] m1_bus_addr,
  input  logic [DataWidth-1:0] m1_bus_data_m,
  input  logic [SelWidth-1:0]  m1_bus_sel,
  output logic [DataWidth-1:0] m1_bus_data_s,
  output logic                 m1_bus_ack,
  output logic                 m1_bus_stall,
  output logic                 m1_bus_err,

  output logic                 s_bus_cyc,
  output logic                 s_bus_stb,
  output logic                 s_bus_we,
  output logic [AddrWidth-1:0] s_bus_addr,
  output logic [DataWidth-1:0] s_bus_data_m,
  output logic [SelWidth-1:0]  s_bus_sel,
  input  logic [DataWidth-1:0] s_bus_data_s,
  input  logic                 s_bus_ack,
  input  logic                 s_bus_stall,
  input  logic                 s_bus_err,

  output bus_state_t           dbg_state,
  output logic [CntWidth-1:0]  dbg_outstanding
);

  // Handshake: a request transfers on a cycle where stb=1 and stall=0 (stb is valid, !stall is ready);
  // each transferred request is answered by exactly one cycle of ack or err.
  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  bus_state_t          state, state_next;
  logic                last_grant, last_grant_next;
  logic [CntWidth-1:0] outstanding;
  logic                full;
  logic                accept;
  logic                respond;

  // last = 1 means master 1 held the bus most recently, so master 0 wins a tie.
  function automatic bus_state_t pick_grant(input logic cyc0, input logic cyc1, input logic last);
    bus_state_t g;
    g = IDLE;
    if (cyc0 && cyc1) g = last ? GRANT0 : GRANT1;
    else if (cyc0)    g = GRANT0;
    else if (cyc1)    g = GRANT1;
    return g;
  endfunction

  assign full            = (outstanding == MaxCnt);
  assign accept          = s_bus_stb && !s_bus_stall;
  assign respond         = (s_bus_ack || s_bus_err) && (outstanding != '0);
  assign dbg_state       = state;
  assign dbg_outstanding = outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE:    state_next = pick_grant(m0_bus_cyc, m1_bus_cyc, last_grant);
      GRANT0:  if (!m0_bus_cyc && outstanding == '0)
                 state_next = pick_grant(m0_bus_cyc, m1_bus_cyc, last_grant);
      GRANT1:  if (!m1_bus_cyc && outstanding == '0)
                 state_next = pick_grant(m0_bus_cyc, m1_bus_cyc, last_grant);
      default: state_next = IDLE;
    endcase
    if (state_next != state) begin
      if (state_next == GRANT0) last_grant_next = 1'b0;
      if (state_next == GRANT1) last_grant_next = 1'b1;
    end
  end

  // A request and a response in the same cycle cancel; stb gating keeps the count from overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (accept && !respond) begin
      outstanding <= outstanding + 1'b1;
    end else if (respond && !accept) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_comb begin
    s_bus_cyc     = 1'b0;
    s_bus_stb     = 1'b0;
    s_bus_we      = 1'b0;
    s_bus_addr    = '0;
    s_bus_data_m  = '0;
    s_bus_sel     = '0;
    m0_bus_data_s = '0;
    m0_bus_ack    = 1'b0;
    m0_bus_err    = 1'b0;
    m0_bus_stall  = 1'b1;
    m1_bus_data_s = '0;
    m1_bus_ack    = 1'b0;
    m1_bus_err    = 1'b0;
    m1_bus_stall  = 1'b1;
    case (state)
      GRANT0: begin
        s_bus_cyc     = m0_bus_cyc || (outstanding != '0);
        s_bus_stb     = m0_bus_stb && m0_bus_cyc && !full;
        s_bus_we      = m0_bus_we;
        s_bus_addr    = m0_bus_addr;
        s_bus_data_m  = m0_bus_data_m;
        s_bus_sel     = m0_bus_sel;
        m0_bus_stall  = s_bus_stall || full;
        m0_bus_ack    = s_bus_ack;
        m0_bus_err    = s_bus_err;
        m0_bus_data_s = s_bus_data_s;
      end
      GRANT1: begin
        s_bus_cyc     = m1_bus_cyc || (outstanding != '0);
        s_bus_stb     = m1_bus_stb && m1_bus_cyc && !full;
        s_bus_we      = m1_bus_we;
        s_bus_addr    = m1_bus_addr;
        s_bus_data_m  = m1_bus_data_m;
        s_bus_sel     = m1_bus_sel;
        m1_bus_stall  = s_bus_stall || full;
        m1_bus_ack    = s_bus_ack;
        m1_bus_err    = s_bus_err;
        m1_bus_data_s = s_bus_data_s;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2: vector table, directed corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_bus_arbiter2;
  import bus_pkg::*;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m_cyc[2], m_stb[2], m_we[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data_m[2];
  logic [SW-1:0] m_sel[2];
  logic [DW-1:0] m_data_s[2];
  logic          m_ack[2], m_stall[2], m_err[2];
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data_m;
  logic [SW-1:0] s_sel;
  logic [DW-1:0] s_data_s;
  logic          s_ack, s_stall, s_err;
  bus_state_t    dbg_state;
  logic [2:0]    dbg_outstanding;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: granted master (-1 none), last granted master, requests in flight
  int mdl_gnt, mdl_last, mdl_out;

  bus_state_t    obs_state;
  logic [2:0]    obs_out;
  logic          obs_stall[2], obs_ack[2], obs_err[2];
  logic [DW-1:0] obs_data[2];
  logic          obs_scyc, obs_sstb;

  always #5 clk = ~clk;

  bus_arbiter2 #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_bus_cyc(m_cyc[0]), .m0_bus_stb(m_stb[0]), .m0_bus_we(m_we[0]),
    .m0_bus_addr(m_addr[0]), .m0_bus_data_m(m_data_m[0]), .m0_bus_sel(m_sel[0]),
    .m0_bus_data_s(m_data_s[0]), .m0_bus_ack(m_ack[0]), .m0_bus_stall(m_stall[0]), .m0_bus_err(m_err[0]),
    .m1_bus_cyc(m_cyc[1]), .m1_bus_stb(m_stb[1]), .m1_bus_we(m_we[1]),
    .m1_bus_addr(m_addr[1]), .m1_bus_data_m(m_data_m[1]), .m1_bus_sel(m_sel[1]),
    .m1_bus_data_s(m_data_s[1]), .m1_bus_ack(m_ack[1]), .m1_bus_stall(m_stall[1]), .m1_bus_err(m_err[1]),
    .s_bus_cyc(s_cyc), .s_bus_stb(s_stb), .s_bus_we(s_we), .s_bus_addr(s_addr),
    .s_bus_data_m(s_data_m), .s_bus_sel(s_sel), .s_bus_data_s(s_data_s),
    .s_bus_ack(s_ack), .s_bus_stall(s_stall), .s_bus_err(s_err),
    .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bus_state_t exp_state(input int g);
    if (g == 0) return GRANT0;
    if (g == 1) return GRANT1;
    return IDLE;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0;
      m_addr[i] = '0; m_data_m[i] = '0; m_sel[i] = '0;
    end
    s_data_s = '0; s_ack = 0; s_stall = 0; s_err = 0;
  endtask

  task automatic model_reset();
    mdl_gnt = -1; mdl_last = 1; mdl_out = 0;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_state"}, 128'(dbg_state), 128'(IDLE));
    chk({nm, "_stalls"}, {m_stall[0], m_stall[1]}, 2'b11);
    chk({nm, "_resp"}, {m_ack[0], m_ack[1], m_err[0], m_err[1]}, 4'b0);
    chk({nm, "_scyc"}, {s_cyc, s_stb, dbg_outstanding}, 5'b0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // One bus cycle: predict from the model, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [DW-1:0] e_data[2];
    logic e_ack[2], e_err[2], e_stall[2];
    logic e_scyc, e_sstb, e_swe, acc, rsp, rel;
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_sdata;
    logic [SW-1:0] e_ssel;
    int n, nx;
    for (int i = 0; i < 2; i++) begin
      e_data[i] = '0; e_ack[i] = 0; e_err[i] = 0; e_stall[i] = 1;
    end
    e_scyc = 0; e_sstb = 0; e_swe = 0; e_saddr = '0; e_sdata = '0; e_ssel = '0;
    if (mdl_gnt >= 0) begin
      n = mdl_gnt;
      e_scyc = m_cyc[n] || (mdl_out != 0);
      e_sstb = m_stb[n] && m_cyc[n] && (mdl_out < MAXO);
      e_swe = m_we[n]; e_saddr = m_addr[n]; e_sdata = m_data_m[n]; e_ssel = m_sel[n];
      e_stall[n] = s_stall || (mdl_out == MAXO);
      e_ack[n] = s_ack; e_err[n] = s_err; e_data[n] = s_data_s;
    end
    @(negedge clk);
    obs_state = dbg_state; obs_out = dbg_outstanding; obs_scyc = s_cyc; obs_sstb = s_stb;
    for (int i = 0; i < 2; i++) begin
      obs_stall[i] = m_stall[i]; obs_ack[i] = m_ack[i]; obs_err[i] = m_err[i]; obs_data[i] = m_data_s[i];
    end
    chk("m0_resp", {m_data_s[0], m_ack[0], m_err[0], m_stall[0]}, {e_data[0], e_ack[0], e_err[0], e_stall[0]});
    chk("m1_resp", {m_data_s[1], m_ack[1], m_err[1], m_stall[1]}, {e_data[1], e_ack[1], e_err[1], e_stall[1]});
    chk("slave_req", {s_cyc, s_stb, s_we, s_addr, s_data_m, s_sel},
        {e_scyc, e_sstb, e_swe, e_saddr, e_sdata, e_ssel});
    chk("state_cnt", {dbg_state, dbg_outstanding}, {exp_state(mdl_gnt), 3'(mdl_out)});
    @(posedge clk);
    acc = e_sstb && !s_stall;
    rsp = (s_ack || s_err) && (mdl_out > 0);
    rel = 1;
    if (mdl_gnt >= 0) rel = !m_cyc[mdl_gnt] && (mdl_out == 0);
    mdl_out = mdl_out + int'(acc) - int'(rsp);
    if (rel) begin
      if (m_cyc[0] && m_cyc[1]) nx = 1 - mdl_last;
      else if (m_cyc[0])        nx = 0;
      else if (m_cyc[1])        nx = 1;
      else                      nx = -1;
      if (nx >= 0) mdl_last = nx;
      mdl_gnt = nx;
    end
    #1;
  endtask

  typedef struct {
    logic c0, s0, c1, s1, sst, ack, err;
    int   gnt;
    logic st0, st1, scyc, sstb, ack1, err1;
    int   out;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int acks, m1acks, stalls, k, acc;
    logic ack_pend;

    // tie to m0, hand-over to m1 without IDLE, err+accept in one cycle, next tie to m0
    tbl[0] = '{1,0,1,0,0,0,0, -1, 1,1,0,0,0,0, 0};
    tbl[1] = '{1,1,1,0,0,0,0,  0, 0,1,1,1,0,0, 0};
    tbl[2] = '{1,0,1,0,0,1,0,  0, 0,1,1,0,0,0, 1};
    tbl[3] = '{0,0,1,0,0,0,0,  0, 0,1,0,0,0,0, 0};
    tbl[4] = '{0,0,1,1,0,0,0,  1, 1,0,1,1,0,0, 0};
    tbl[5] = '{0,0,1,1,0,0,1,  1, 1,0,1,1,0,1, 1};
    tbl[6] = '{0,0,1,0,0,1,0,  1, 1,0,1,0,1,0, 1};
    tbl[7] = '{0,0,0,0,0,0,0,  1, 1,0,0,0,0,0, 0};
    tbl[8] = '{1,0,1,0,0,0,0, -1, 1,1,0,0,0,0, 0};
    tbl[9] = '{1,0,1,0,0,0,0,  0, 0,1,1,0,0,0, 0};

    clear_inputs();
    model_reset();
    rst_n = 0;
    #1;
    check_reset_outputs("por");
    do_reset();

    for (int i = 0; i < 10; i++) begin
      m_cyc[0] = tbl[i].c0; m_stb[0] = tbl[i].s0; m_cyc[1] = tbl[i].c1; m_stb[1] = tbl[i].s1;
      s_stall = tbl[i].sst; s_ack = tbl[i].ack; s_err = tbl[i].err;
      m_addr[1] = AW'(i); s_data_s = 32'hC0DE_0000 + DW'(i);
      cycle();
      chk($sformatf("tbl%0d", i),
          {obs_state, obs_stall[0], obs_stall[1], obs_scyc, obs_sstb, obs_ack[1], obs_err[1], obs_out},
          {exp_state(tbl[i].gnt), tbl[i].st0, tbl[i].st1, tbl[i].scyc, tbl[i].sstb,
           tbl[i].ack1, tbl[i].err1, 3'(tbl[i].out)});
    end

    // single master burst to addresses 0..3, slave acks one cycle after acceptance
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1; m_addr[0] = '0;
    k = 0; acks = 0; m1acks = 0; stalls = 0; ack_pend = 0;
    for (int c = 0; c < 8; c++) begin
      s_ack = ack_pend;
      s_data_s = $urandom;
      if (k >= 4) m_stb[0] = 0;
      cycle();
      if (c < 5 && obs_stall[0]) stalls++;
      if (c == 0) chk("single_first_stall", 128'(obs_stall[0]), 128'(1));
      if (obs_ack[0]) begin
        acks++;
        chk("single_data", 128'(obs_data[0]), 128'(s_data_s));
      end
      if (obs_ack[1]) m1acks++;
      ack_pend = obs_sstb && !s_stall;
      if (ack_pend) begin
        k++;
        m_addr[0] = AW'(k);
      end
    end
    chk("single_acks", 128'(acks), 128'(4));
    chk("single_m1_acks", 128'(m1acks), 128'(0));
    chk("single_stall_cycles", 128'(stalls), 128'(1));

    // backpressure: no acks, stream stops at MaxOutstanding
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1; acc = 0;
    for (int c = 0; c < 7; c++) begin
      m_addr[0] = AW'($urandom);
      cycle();
      if (obs_sstb && !s_stall) acc++;
    end
    chk("bp_accepted", 128'(acc), 128'(MAXO));
    chk("bp_full", {obs_out, obs_stall[0]}, {3'(MAXO), 1'b1});
    s_ack = 1;
    cycle();
    s_ack = 0;
    cycle();
    chk("bp_after_ack", {obs_out, obs_stall[0]}, {3'(MAXO - 1), 1'b0});

    // drain: m0 drops cyc with two in flight while m1 waits
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1;
    repeat (3) cycle();
    m_cyc[0] = 0; m_stb[0] = 0; m_cyc[1] = 1; m_stb[1] = 1;
    for (int c = 0; c < 4; c++) begin
      s_ack = (c >= 2);
      cycle();
      chk($sformatf("drain_hold%0d", c), {obs_state, obs_scyc, obs_sstb}, {GRANT0, 1'b1, 1'b0});
    end
    s_ack = 0;
    cycle();
    chk("drain_release", {obs_state, obs_out, obs_scyc}, {GRANT0, 3'd0, 1'b0});
    cycle();
    chk("drain_grant1", 128'(obs_state), 128'(GRANT1));

    // reset asserted mid-burst with three requests in flight
    do_reset();
    m_cyc[0] = 1; m_stb[0] = 1;
    repeat (4) cycle();
    chk("rst_pre_out", 128'(dbg_outstanding), 128'(3));
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    m_cyc[0] = 1; m_cyc[1] = 1;
    cycle();
    cycle();
    chk("rst_tie_m0", 128'(obs_state), 128'(GRANT0));

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[i] = !m_cyc[i];
        m_stb[i] = ($urandom_range(0, 1) == 1);
        m_we[i] = ($urandom_range(0, 1) == 1);
        m_addr[i] = AW'($urandom);
        m_data_m[i] = $urandom;
        m_sel[i] = SW'($urandom);
      end
      s_stall = ($urandom_range(0, 3) == 0);
      s_ack = ($urandom_range(0, 2) == 0);
      s_err = !s_ack && ($urandom_range(0, 15) == 0);
      s_data_s = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
